vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Upstream timing stage for the tt_um_vga_example pixel logic. Generates 640x480@60 Hz VGA raster counters (hpos, vpos), hsync/vsync, a display-active flag and line/frame strobes from the 25.175 MHz project clock. Pattern/colour logic consumes hpos/vpos/display_on and drives uo_out alongside hsync/vsync. Raster position is tracked by horizontal and vertical phase FSMs.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level (0 = active-low)

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  count enable (TT ena); low = freeze
hpos  output  10  current pixel column, 0..H_TOTAL-1
vpos  output  10  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, level per HSYNC_POL
vsync  output  1  vertical sync, level per VSYNC_POL
display_on  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
line_start  output  1  one-cycle pulse when hpos==0
frame_start  output  1  one-cycle pulse when hpos==0 and vpos==0
frame_count  output  8  frames started, mod 256 (only with VGA_FRAME_COUNTER_EN)

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). All state registered.
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must fit in 10 bits.
- Reset values: hpos=H_TOTAL-1 (799), vpos=V_TOTAL-1 (524), hsync=vsync=inactive level (1 with defaults), display_on=0, line_start=0, frame_start=0, frame_count=0. Consequence: first enabled edge after reset lands on (0,0) with frame_start=1.
- All outputs registered, computed from next-state values: every output is coherent with hpos/vpos in the same cycle (zero relative latency).
- Horizontal FSM: H_ACTIVE (0..639) -> H_FRONT (640..655) -> H_SYNC (656..751) -> H_BACK (752..799) -> H_ACTIVE. Transition when hpos reaches the last value of the phase.
- Vertical FSM: V_ACTIVE (0..479) -> V_FRONT (480..489) -> V_SYNC (490..491) -> V_BACK (492..524) -> V_ACTIVE. Advances only on horizontal wrap (hpos 799->0).
- hpos wraps 799->0 and vpos increments on the same edge. At (799,524) both wrap to (0,0) simultaneously.
- hsync asserted (active level) iff H FSM in H_SYNC; vsync asserted iff V FSM in V_SYNC. vsync changes aligned with hpos==0.
- ena=0: counters, FSMs and all level outputs hold. line_start/frame_start forced 0 while ena=0. They re-pulse only on a new enabled entry to hpos==0.
- rst_n assertion mid-frame: immediate return to reset values regardless of clk/ena. Restart after release is identical to power-up.
- Exactly H_TOTAL*V_TOTAL = 420000 enabled cycles between consecutive frame_start pulses.

Optional Feature:
- Macro VGA_FRAME_COUNTER_EN.
- Defined: frame_count port present. It increments by 1 on each enabled edge that produces frame_start, wrapping 255->0. The increment is visible in the same cycle as the frame_start pulse, so the first frame after reset reads 1. Reset value 0.
- Undefined: frame_count port and its register omitted. All other behaviour unchanged.

Test Plan:
- Reset: rst_n=0 -> hpos=799, vpos=524, hsync=1, vsync=1, display_on=0, strobes=0. Release with ena=1, one edge -> hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1.
- Line timing: count a full line -> hsync low exactly for hpos 656..751 (96 cycles). display_on low for hpos 640..799. Edge at hpos=799 -> hpos=0, vpos+1, line_start=1.
- Frame timing: vsync low only for vpos 490..491 (1600 cycles). frame_start pulses exactly 420000 cycles apart. Wrap (799,524)->(0,0).
- Enable hold: drop ena at hpos=300, vpos=100 for 50 cycles -> all outputs frozen, strobes 0. Resume -> hpos=301 next edge.
- Mid-frame reset: assert rst_n=0 asynchronously at vpos=491 during vsync -> outputs immediately at reset values (vsync=1). After release, timing restarts from (0,0).
- VGA_FRAME_COUNTER_EN defined: run 257 frames -> frame_count reads 1 at the first frame_start, wraps to 0 at the 256th, and reads 1 at the 257th.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: hpos/vpos counters, hsync/vsync, display_on, line/frame strobes.
// Latency: every output is registered from next-state values, so all are coherent with hpos/vpos.
// Backpressure: none; ena=0 freezes all state and forces the strobes low. Optional frame_count via VGA_FRAME_COUNTER_EN.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Last counter value of each phase; the FSMs leave a phase on these values.
  localparam logic [9:0] H_ACT_END = 10'(H_DISPLAY - 1);
  localparam logic [9:0] H_FP_END  = 10'(H_DISPLAY + H_FRONT - 1);
  localparam logic [9:0] H_SY_END  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_END     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_DISPLAY - 1);
  localparam logic [9:0] V_FP_END  = 10'(V_DISPLAY + V_FRONT - 1);
  localparam logic [9:0] V_SY_END  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_END     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

  h_state_t   h_state, h_next;
  v_state_t   v_state, v_next;
  logic [9:0] hpos_next, vpos_next;
  logic       h_wrap, v_wrap;
  logic       hsync_next, vsync_next, display_on_next;

  // Next raster position, phase transitions and the output levels they imply.
  always_comb begin
    h_next    = h_state;
    v_next    = v_state;
    hpos_next = hpos;
    vpos_next = vpos;
    h_wrap    = 1'b0;
    v_wrap    = 1'b0;
    if (ena) begin
      h_wrap    = (hpos == H_END);
      v_wrap    = h_wrap && (vpos == V_END);
      hpos_next = h_wrap ? 10'd0 : hpos + 10'd1;
      if (h_wrap) begin
        vpos_next = v_wrap ? 10'd0 : vpos + 10'd1;
      end
      case (h_state)
        H_ACT:   if (hpos == H_ACT_END) h_next = H_FP;
        H_FP:    if (hpos == H_FP_END)  h_next = H_SY;
        H_SY:    if (hpos == H_SY_END)  h_next = H_BP;
        H_BP:    if (hpos == H_END)     h_next = H_ACT;
        default: h_next = H_ACT;
      endcase
      // The vertical phase only moves on the horizontal wrap edge.
      if (h_wrap) begin
        case (v_state)
          V_ACT:   if (vpos == V_ACT_END) v_next = V_FP;
          V_FP:    if (vpos == V_FP_END)  v_next = V_SY;
          V_SY:    if (vpos == V_SY_END)  v_next = V_BP;
          V_BP:    if (vpos == V_END)     v_next = V_ACT;
          default: v_next = V_ACT;
        endcase
      end
    end
    hsync_next      = (h_next == H_SY) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next      = (v_next == V_SY) ? VSYNC_POL : ~VSYNC_POL;
    display_on_next = (h_next == H_ACT) && (v_next == V_ACT);
  end

  // Raster state and registered outputs; reset parks on the last pixel of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state     <= H_BP;
      v_state     <= V_BP;
      hpos        <= H_END;
      vpos        <= V_END;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_state     <= h_next;
      v_state     <= v_next;
      hpos        <= hpos_next;
      vpos        <= vpos_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      display_on  <= display_on_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  // Frame counter steps together with frame_start, so frame one reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= 8'd0;
    end else if (v_wrap) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // Instance A: full 640x480 timing. Instance B: a miniature raster so whole frames fit the run.
  localparam int AHD = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVD = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int BHD = 8,   BHF = 2,  BHS = 3,  BHB = 2;
  localparam int BVD = 4,   BVF = 1,  BVS = 2,  BVB = 2;
  localparam int AHT = AHD + AHF + AHS + AHB;
  localparam int AVT = AVD + AVF + AVS + AVB;
  localparam int BHT = BHD + BHF + BHS + BHB;
  localparam int BVT = BVD + BVF + BVS + BVB;
  localparam int LOOP_LIMIT = 40000;

  typedef struct packed {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
  logic       a_hsync, a_vsync, a_disp, a_ls, a_fs;
  logic       b_hsync, b_vsync, b_disp, b_ls, b_fs;
  logic [7:0] a_fc, b_fc;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hsync), .vsync(a_vsync),
    .display_on(a_disp), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync), .vsync(b_vsync),
    .display_on(b_disp), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(b_fc)
`endif
  );

`ifndef VGA_FRAME_COUNTER_EN
  assign a_fc = 8'h00;
  assign b_fc = 8'h00;
`endif

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  out_t qa[$];
  out_t qb[$];
  int   ha, va, fca, hb, vb, fcb;
  bit   lsa, fsa, lsb, fsb;
  int   b_cycle, b_last_fs;
  int   hsync_low, disp_off, pulses, guard;

  // Reference outputs derived from the raster position by plain range tests.
  function automatic out_t mk(int hp, int vp, bit ls, bit fs, int fc,
                              int hd, int hf, int hs, int vd, int vf, int vs,
                              bit hpol, bit vpol);
    out_t o;
    o.hpos        = 10'(hp);
    o.vpos        = 10'(vp);
    o.hsync       = (hp >= hd + hf && hp < hd + hf + hs) ? hpol : ~hpol;
    o.vsync       = (vp >= vd + vf && vp < vd + vf + vs) ? vpol : ~vpol;
    o.display_on  = (hp < hd) && (vp < vd);
    o.line_start  = ls;
    o.frame_start = fs;
`ifdef VGA_FRAME_COUNTER_EN
    o.frame_count = 8'(fc);
`else
    o.frame_count = 8'h00 & 8'(fc);
`endif
    return o;
  endfunction

  task automatic adv(input int h_i, input int v_i, input int fc_i, input int ht, input int vt,
                     input bit en, output int h_o, output int v_o, output int fc_o,
                     output bit ls, output bit fs);
    h_o = h_i; v_o = v_i; fc_o = fc_i; ls = 1'b0; fs = 1'b0;
    if (en) begin
      if (h_i == ht - 1) begin
        h_o = 0;
        ls  = 1'b1;
        if (v_i == vt - 1) begin
          v_o  = 0;
          fs   = 1'b1;
          fc_o = (fc_i + 1) % 256;
        end else begin
          v_o = v_i + 1;
        end
      end else begin
        h_o = h_i + 1;
      end
    end
  endtask

  task automatic check(input string tag, input out_t obs, input out_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ha = AHT - 1; va = AVT - 1; fca = 0; lsa = 1'b0; fsa = 1'b0;
    hb = BHT - 1; vb = BVT - 1; fcb = 0; lsb = 1'b0; fsb = 1'b0;
    b_last_fs = -1;
  endtask

  task automatic push_expected();
    qa.push_back(mk(ha, va, lsa, fsa, fca, AHD, AHF, AHS, AVD, AVF, AVS, 1'b0, 1'b0));
    qb.push_back(mk(hb, vb, lsb, fsb, fcb, BHD, BHF, BHS, BVD, BVF, BVS, 1'b1, 1'b0));
  endtask

  task automatic pop_compare();
    out_t e;
    if (qa.size() == 0) begin
      chk_int("qa_depth", 0, 1);
    end else begin
      e = qa.pop_front();
      check("dut_a", {a_hpos, a_vpos, a_hsync, a_vsync, a_disp, a_ls, a_fs, a_fc}, e);
    end
    if (qb.size() == 0) begin
      chk_int("qb_depth", 0, 1);
    end else begin
      e = qb.pop_front();
      check("dut_b", {b_hpos, b_vpos, b_hsync, b_vsync, b_disp, b_ls, b_fs, b_fc}, e);
    end
  endtask

  // One clock: drive ena, queue the predicted outputs, then compare after the edge.
  task automatic step(input bit en);
    ena = en;
    adv(ha, va, fca, AHT, AVT, en, ha, va, fca, lsa, fsa);
    adv(hb, vb, fcb, BHT, BVT, en, hb, vb, fcb, lsb, fsb);
    push_expected();
    @(posedge clk);
    @(negedge clk);
    pop_compare();
    if (en) b_cycle++;
    if (b_fs === 1'b1) begin
      if (b_last_fs >= 0) chk_int("b_frame_period", b_cycle - b_last_fs, BHT * BVT);
      b_last_fs = b_cycle;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b0;
    b_cycle = 0;
    model_reset();

    // Reset state, held with ena raised to show ena has no effect in reset.
    repeat (3) @(negedge clk);
    ena = 1'b1;
    #1;
    push_expected();
    pop_compare();

    // First enabled edge lands on (0,0) with both strobes.
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    chk_int("a_first_frame_start", int'(a_fs), 1);

    // One full line of instance A: sync width and blanking width.
    hsync_low = 0;
    disp_off  = 0;
    for (int i = 0; i < AHT; i++) begin
      if (a_hsync === 1'b0) hsync_low++;
      if (a_disp === 1'b0) disp_off++;
      step(1'b1);
    end
    chk_int("a_hsync_low_cycles", hsync_low, AHS);
    chk_int("a_blank_cycles", disp_off, AHF + AHS + AHB);
    chk_int("a_line_wrap_vpos", int'(a_vpos), 1);

    // Enable hold mid-line, then resume.
    guard = 0;
    while (ha != 300 && guard < LOOP_LIMIT) begin step(1'b1); guard++; end
    chk_int("reach_hpos_300", int'(guard < LOOP_LIMIT), 1);
    for (int i = 0; i < 50; i++) step(1'b0);
    step(1'b1);
    chk_int("a_resume_hpos", int'(a_hpos), 301);

    // Run instance B into its last vsync line, then reset asynchronously.
    guard = 0;
    while (!(vb == BVD + BVF + BVS - 1 && hb == 3) && guard < LOOP_LIMIT) begin
      step(1'b1);
      guard++;
    end
    chk_int("reach_b_vsync", int'(guard < LOOP_LIMIT), 1);
    chk_int("b_vsync_active", int'(b_vsync), 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_expected();
    pop_compare();
    chk_int("b_vsync_after_reset", int'(b_vsync), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    chk_int("b_restart_frame_start", int'(b_fs), 1);

`ifdef VGA_FRAME_COUNTER_EN
    // 257 frames on instance B: counter reads 1, wraps to 0 at 256, then 1 again.
    chk_int("b_fc_frame1", int'(b_fc), 1);
    pulses = 1;
    guard  = 0;
    while (pulses < 257 && guard < LOOP_LIMIT) begin
      step(1'b1);
      guard++;
      if (b_fs === 1'b1) begin
        pulses++;
        if (pulses == 256) chk_int("b_fc_frame256", int'(b_fc), 0);
        if (pulses == 257) chk_int("b_fc_frame257", int'(b_fc), 1);
      end
    end
    chk_int("b_257_frames_seen", pulses, 257);
`else
    pulses = 1;
    for (int i = 0; i < 3 * BHT * BVT; i++) begin
      step(1'b1);
      if (b_fs === 1'b1) pulses++;
    end
    chk_int("b_frames_seen", pulses, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
